rightshift_iter: RTL and testbench

//   Iterative logical/arithmetic right shifter for the ALU, the counterpart of the iterative left shifter.

---
 rtl/alu_pkg.sv | 15 +
 rtl/rshift_stage.sv | 21 ++
 rtl/rightshift_iter.sv | 120 ++++++++++++
 tb/tb_rightshift_iter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes and shifter state encoding
package alu_pkg;

  localparam int CTRL_W = 5;

  localparam logic [CTRL_W-1:0] CTRL_SRL = 5'd6;
  localparam logic [CTRL_W-1:0] CTRL_SRA = 5'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/rshift_stage.sv
// rtl/rshift_stage.sv - one combinational right-shift stage, amount given as a one-hot mask
module rshift_stage #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] mask,
  input  logic               enable,
  input  logic               fill,
  output logic [WIDTH-1:0]   shifted
);

  logic [WIDTH-1:0] fill_bits;

  // Shift by the numeric value of the one-hot mask; vacated top bits take the fill bit.
  always_comb begin
    fill_bits = fill ? ~({WIDTH{1'b1}} >> mask) : '0;
    shifted   = enable ? ((data >> mask) | fill_bits) : data;
  end

endmodule

// File: rtl/rightshift_iter.sv
// rtl/rightshift_iter.sv - iterative right shifter, one shift-amount bit per cycle; ARITH_SHIFT_EN enables SRA
module rightshift_iter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] b,
  input  logic [CTRL_W-1:0]  ctrl,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out
);

  state_t state, state_next;

  logic               accept;
  logic               last_stage;
  logic               stage_en;
  logic               fill;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   shifted;
  logic [SHAMT_W-1:0] b_r;
  logic [SHAMT_W-1:0] mask;

`ifdef ARITH_SHIFT_EN
  logic [CTRL_W-1:0] op_r;
  logic              sign_r;

  // Sign captured at accept so the fill stays constant across all stages.
  assign fill = (op_r == CTRL_SRA) & sign_r;
`else
  logic unused_ctrl;

  // Logical-only build: the op code has no effect.
  assign unused_ctrl = ^ctrl;
  assign fill        = 1'b0;
`endif

  assign last_stage = mask[SHAMT_W-1];
  assign stage_en   = |(b_r & mask);

  rshift_stage #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_stage (
    .data    (a_r),
    .mask    (mask),
    .enable  (stage_en),
    .fill    (fill),
    .shifted (shifted)
  );

  // Next-state and handshake decode; a new op may be taken whenever not mid-shift.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE, DONE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (last_stage) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture, per-cycle stage update and result hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      mask      <= '0;
      out       <= '0;
      out_valid <= 1'b0;
`ifdef ARITH_SHIFT_EN
      op_r      <= '0;
      sign_r    <= 1'b0;
`endif
    end else if (accept) begin
      a_r       <= a;
      b_r       <= b;
      mask      <= {{(SHAMT_W-1){1'b0}}, 1'b1};
      out_valid <= 1'b0;
`ifdef ARITH_SHIFT_EN
      op_r      <= ctrl;
      sign_r    <= a[WIDTH-1];
`endif
    end else if (state == SHIFT) begin
      a_r  <= shifted;
      mask <= mask << 1;
      if (last_stage) begin
        out       <= shifted;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rightshift_iter.sv
// tb/tb_rightshift_iter.sv - self-checking bench for rightshift_iter against an arithmetic reference
module tb_rightshift_iter;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [SW-1:0] b;
  logic [4:0]    ctrl;
  logic          out_valid;
  logic [W-1:0]  out;

  int            total;
  int            bad;
  logic [W-1:0]  prev_out;

  rightshift_iter #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] av, input logic [SW-1:0] bv,
                                         input logic [4:0] cv);
    logic arith;
    arith = 1'b0;
`ifdef ARITH_SHIFT_EN
    arith = (cv == 5'd7);
`endif
    if (arith) return W'($signed(av) >>> bv);
    return av >> bv;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [SW-1:0] bv,
                        input logic [4:0] cv, input bit glitch);
    logic [W-1:0] exp;
    exp = model(av, bv, cv);
    chk({tag, "_ready_pre"}, W'(in_ready), W'(1));
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    ctrl     = cv;
    tick();
    in_valid = 1'b0;
    a        = $urandom;
    b        = SW'($urandom);
    chk({tag, "_valid_clr"}, W'(out_valid), W'(0));
    chk({tag, "_out_kept"}, out, prev_out);
    chk({tag, "_busy0"}, W'(in_ready), W'(0));
    for (int k = 1; k < SW; k++) begin
      if (glitch && k == 2) begin
        in_valid = 1'b1;
        a        = ~av;
        b        = ~bv;
        ctrl     = 5'd7;
      end
      tick();
      in_valid = 1'b0;
      chk({tag, "_valid_early"}, W'(out_valid), W'(0));
      chk({tag, "_busy"}, W'(in_ready), W'(0));
    end
    tick();
    chk({tag, "_valid"}, W'(out_valid), W'(1));
    chk({tag, "_out"}, out, exp);
    chk({tag, "_ready_post"}, W'(in_ready), W'(1));
    prev_out = exp;
  endtask

  initial begin
    logic [4:0] rc;
    total    = 0;
    bad      = 0;
    prev_out = '0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    ctrl     = 5'd6;
    #12;
    chk("rst_valid", W'(out_valid), W'(0));
    chk("rst_out", out, '0);
    chk("rst_ready", W'(in_ready), W'(1));
    rst = 1'b0;
    tick();

    run_op("t1_srl31", 32'h8000_0000, 5'd31, 5'd6, 1'b0);
    chk("t1_lit", out, 32'h0000_0001);
    run_op("t2_srl21", 32'hFFFF_FFFF, 5'b10101, 5'd6, 1'b0);
    chk("t2_lit", out, 32'h0000_07FF);
    run_op("t3_sra4", 32'h8000_0000, 5'd4, 5'd7, 1'b0);
`ifdef ARITH_SHIFT_EN
    chk("t3_lit", out, 32'hF800_0000);
`else
    chk("t3_lit", out, 32'h0800_0000);
`endif
    run_op("t4_b0", 32'h1234_5678, 5'd0, 5'd6, 1'b0);
    chk("t4_lit", out, 32'h1234_5678);

    run_op("t5_glitch", 32'hCAFE_F00D, 5'd9, 5'd6, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_hold_valid", W'(out_valid), W'(1));
      chk("t5_hold_out", out, prev_out);
    end
    run_op("t5_next", 32'hF0F0_1234, 5'd13, 5'd7, 1'b0);

    in_valid = 1'b1;
    a        = 32'hDEAD_BEEF;
    b        = 5'd3;
    ctrl     = 5'd6;
    tick();
    in_valid = 1'b0;
    tick();
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", W'(out_valid), W'(0));
    chk("t6_rst_out", out, '0);
    chk("t6_rst_ready", W'(in_ready), W'(1));
    #1;
    rst = 1'b0;
    prev_out = '0;
    tick();
    chk("t6_idle_valid", W'(out_valid), W'(0));
    chk("t6_idle_out", out, '0);
    run_op("t6_fresh", 32'h8765_4321, 5'd17, 5'd7, 1'b0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       rc = 5'd6;
        1:       rc = 5'd7;
        default: rc = 5'($urandom_range(0, 31));
      endcase
      run_op("rand", $urandom, SW'($urandom), rc, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
